// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a request-to-send,
// then shifts out start, 8 data bits, odd parity and stop on device clock edges.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int SETUP_CYCLES   = 50,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int PHASE_MAX = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
    localparam int PHASE_W   = $clog2(PHASE_MAX + 1);
    localparam int TIMEOUT_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [PHASE_W-1:0]   INHIBIT_LAST = PHASE_W'(INHIBIT_CYCLES - 1);
    localparam logic [PHASE_W-1:0]   SETUP_LAST   = PHASE_W'(SETUP_CYCLES - 1);
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_INHIBIT  = 3'd1;
    localparam logic [2:0] ST_REQ      = 3'd2;
    localparam logic [2:0] ST_SHIFT    = 3'd3;
    localparam logic [2:0] ST_ACK_WAIT = 3'd4;
    localparam logic [2:0] ST_BUS_IDLE = 3'd5;

    logic [2:0]           state;
    logic [PHASE_W-1:0]   phase_cnt;
    logic [TIMEOUT_W-1:0] timeout_cnt;
    logic [3:0]           bit_cnt;
    logic [7:0]           data_q;
    logic                 parity_q;
    logic [8:0]           payload;

    logic clk_meta, clk_sync, clk_prev;
    logic data_meta, data_sync;
    logic clk_fall;
    logic timed_out;

    // Idle bus level is high, so the synchronizers reset to 1 to avoid a false edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            clk_prev  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            clk_meta  <= ps2_clk_in;
            clk_sync  <= clk_meta;
            clk_prev  <= clk_sync;
            data_meta <= ps2_data_in;
            data_sync <= data_meta;
        end
    end

    assign clk_fall  = clk_prev & ~clk_sync;
    assign payload   = {parity_q, data_q};
    assign timed_out = (timeout_cnt == TIMEOUT_LAST);
    assign tx_busy   = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_done     <= 1'b0;
            tx_error    <= 1'b0;
            phase_cnt   <= '0;
            timeout_cnt <= '0;
            bit_cnt     <= '0;
            data_q      <= '0;
            parity_q    <= 1'b0;
        end else begin
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
            case (state)
                ST_IDLE: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    if (tx_start) begin
                        data_q     <= tx_data;
                        parity_q   <= ~^tx_data;
                        bit_cnt    <= '0;
                        phase_cnt  <= '0;
                        ps2_clk_oe <= 1'b1;
                        state      <= ST_INHIBIT;
                    end
                end
                ST_INHIBIT: begin
                    if (phase_cnt == INHIBIT_LAST) begin
                        phase_cnt   <= '0;
                        ps2_data_oe <= 1'b1;
                        state       <= ST_REQ;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                ST_REQ: begin
                    // Releasing clock with data still low presents the start bit.
                    if (phase_cnt == SETUP_LAST) begin
                        ps2_clk_oe  <= 1'b0;
                        timeout_cnt <= '0;
                        state       <= ST_SHIFT;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (timed_out) begin
                        tx_error    <= 1'b1;
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        state       <= ST_IDLE;
                    end else begin
                        timeout_cnt <= timeout_cnt + 1'b1;
                        if (clk_fall) begin
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == 4'd9) begin
                                ps2_data_oe <= 1'b0;
                                state       <= ST_ACK_WAIT;
                            end else begin
                                ps2_data_oe <= ~payload[bit_cnt];
                            end
                        end
                    end
                end
                ST_ACK_WAIT: begin
                    if (timed_out) begin
                        tx_error    <= 1'b1;
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        state       <= ST_IDLE;
                    end else begin
                        timeout_cnt <= timeout_cnt + 1'b1;
                        if (clk_fall) begin
                            bit_cnt <= bit_cnt + 1'b1;
                            if (!data_sync) begin
                                state <= ST_BUS_IDLE;
                            end else begin
                                tx_error <= 1'b1;
                                state    <= ST_IDLE;
                            end
                        end
                    end
                end
                ST_BUS_IDLE: begin
                    if (timed_out) begin
                        tx_error    <= 1'b1;
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        state       <= ST_IDLE;
                    end else begin
                        timeout_cnt <= timeout_cnt + 1'b1;
                        if (clk_sync && data_sync) begin
                            tx_done <= 1'b1;
                            state   <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: table of frames driven by a simple
// open-collector device model, plus timeout and mid-frame reset sequences.
module tb_ps2_host_tx;

    localparam int INHIBIT = 5000;
    localparam int SETUP   = 50;
    localparam int TIMEOUT = 3000;
    localparam int HALF    = 20;

    typedef struct {
        logic [7:0]  data;
        logic        ack;
        logic        restart;
        logic [7:0]  data2;
        logic [0:10] exp_oe;
        int          exp_done;
        int          exp_err;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       ps2_clk_in, ps2_data_in;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       tx_busy, tx_done, tx_error;

    int errors = 0;
    int checks = 0;
    int done_seen = 0;
    int err_seen = 0;
    int both_seen = 0;
    int busy_after_err = 0;
    logic err_prev = 1'b0;

    vec_t vecs[6];

    // Wired-AND bus: either side can pull a line low.
    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INHIBIT),
        .SETUP_CYCLES  (SETUP),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_error   (tx_error)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (tx_done) done_seen++;
        if (tx_error) err_seen++;
        if (tx_done && tx_error) both_seen++;
        if (err_prev && tx_busy) busy_after_err++;
        err_prev = tx_error;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] d, input logic restart,
                                 input logic [7:0] d2, input string tag);
        int cnt;
        @(negedge clk);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        checkOutput({tag, " busy in inhibit"}, int'(tx_busy), 1);
        cnt = 0;
        while (ps2_clk_oe && !ps2_data_oe && cnt < INHIBIT + 100) begin
            if (restart && cnt == 100) begin
                tx_data  = d2;
                tx_start = 1'b1;
            end else begin
                tx_start = 1'b0;
            end
            cnt++;
            @(negedge clk);
        end
        tx_start = 1'b0;
        checkOutput({tag, " inhibit cycles"}, cnt, INHIBIT);
        cnt = 0;
        while (ps2_clk_oe && ps2_data_oe && cnt < SETUP + 100) begin
            cnt++;
            @(negedge clk);
        end
        checkOutput({tag, " setup cycles"}, cnt, SETUP);
        checkOutput({tag, " clk released"}, int'(ps2_clk_oe), 0);
    endtask

    task automatic devFall(output logic oe);
        repeat (HALF) @(negedge clk);
        oe = ps2_data_oe;
        dev_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        dev_clk = 1'b1;
    endtask

    task automatic runFrame(input vec_t v, input string tag);
        int d0, e0, b0, a0, cnt;
        logic [0:10] got;
        logic oe;
        d0 = done_seen;
        e0 = err_seen;
        b0 = both_seen;
        a0 = busy_after_err;
        applyStimulus(v.data, v.restart, v.data2, tag);
        for (int k = 0; k < 11; k++) begin
            if (k == 10) dev_data = v.ack ? 1'b0 : 1'b1;
            devFall(oe);
            got[k] = oe;
        end
        repeat (HALF) @(negedge clk);
        dev_data = 1'b1;
        cnt = 0;
        while (tx_busy && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        repeat (10) @(negedge clk);
        checkOutput({tag, " data_oe sequence"}, int'(got), int'(v.exp_oe));
        checkOutput({tag, " done pulses"}, done_seen - d0, v.exp_done);
        checkOutput({tag, " error pulses"}, err_seen - e0, v.exp_err);
        checkOutput({tag, " done with error"}, both_seen - b0, 0);
        checkOutput({tag, " busy after error"}, busy_after_err - a0, 0);
        checkOutput({tag, " idle busy"}, int'(tx_busy), 0);
    endtask

    initial begin
        vec_t rv;
        int d0, e0, k;

        vecs[0] = '{8'hED, 1'b1, 1'b0, 8'h00, 11'b10100100000, 1, 0};
        vecs[1] = '{8'h01, 1'b1, 1'b0, 8'h00, 11'b10111111110, 1, 0};
        vecs[2] = '{8'hA5, 1'b0, 1'b0, 8'h00, 11'b10101101000, 0, 1};
        vecs[3] = '{8'h3C, 1'b1, 1'b1, 8'hC3, 11'b11100001100, 1, 0};
        vecs[4] = '{8'h00, 1'b1, 1'b0, 8'h00, 11'b11111111100, 1, 0};
        vecs[5] = '{8'hFF, 1'b1, 1'b0, 8'h00, 11'b10000000000, 1, 0};

        // Reset must win over a simultaneous start request.
        reset    = 1'b1;
        tx_start = 1'b1;
        tx_data  = 8'h55;
        repeat (3) @(negedge clk);
        checkOutput("reset clk_oe", int'(ps2_clk_oe), 0);
        checkOutput("reset data_oe", int'(ps2_data_oe), 0);
        checkOutput("reset busy", int'(tx_busy), 0);
        checkOutput("reset done", int'(tx_done), 0);
        checkOutput("reset error", int'(tx_error), 0);
        reset    = 1'b0;
        tx_start = 1'b0;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            runFrame(vecs[i], $sformatf("vec%0d", i));
        end

        // Device never clocks: error exactly TIMEOUT cycles after clock release.
        d0 = done_seen;
        e0 = err_seen;
        applyStimulus(8'h77, 1'b0, 8'h00, "timeout");
        k = 0;
        while (!tx_error && k < TIMEOUT + 500) begin
            @(negedge clk);
            k++;
        end
        checkOutput("timeout cycles", k, TIMEOUT);
        checkOutput("timeout clk_oe", int'(ps2_clk_oe), 0);
        checkOutput("timeout data_oe", int'(ps2_data_oe), 0);
        repeat (5) @(negedge clk);
        checkOutput("timeout busy", int'(tx_busy), 0);
        checkOutput("timeout errors", err_seen - e0, 1);
        checkOutput("timeout no done", done_seen - d0, 0);

        // Reset mid-frame at n=5 (bit4 of 0xA5 is 0, so data is being driven).
        rv = '{8'hA5, 1'b1, 1'b0, 8'h00, 11'b10101101000, 1, 0};
        applyStimulus(rv.data, 1'b0, 8'h00, "midreset");
        for (int f = 0; f < 5; f++) begin
            logic oe;
            devFall(oe);
        end
        repeat (5) @(negedge clk);
        checkOutput("midreset data_oe before", int'(ps2_data_oe), 1);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midreset clk_oe", int'(ps2_clk_oe), 0);
        checkOutput("midreset data_oe", int'(ps2_data_oe), 0);
        checkOutput("midreset busy", int'(tx_busy), 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        runFrame(rv, "after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
